status_register: RTL

Holds the 4-bit processor status flags `{Z, C, S, O}`. It sits on the output side of the ALU: it captures the ALU's `flags` output into a register and feeds that register back to the ALU `CFlags` input. It also evaluates branch conditions for the Control Unit and keeps a small LIFO of saved flag words, used for interrupt entry and return.

---
 rtl/status_register.sv | 125 ++++++++++++
 1 files changed

// File: rtl/status_register.sv
// Processor status flags {Z, C, S, O} with masked ALU capture, direct write,
// a LIFO save stack for interrupt entry/return, and branch-condition decode.
module status_register #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [3:0] UpdMask,
    input  logic [3:0] ALUFlags,
    input  logic       WrE,
    input  logic [3:0] WrData,
    input  logic       Push,
    input  logic       Pop,
    input  logic [2:0] Cond,
    output logic [3:0] CFlags,
    output logic       CondTrue,
    output logic       StackEmpty,
    output logic       StackFull,
    output logic       StackErr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {
        COND_AL  = 3'b000,
        COND_Z   = 3'b001,
        COND_NZ  = 3'b010,
        COND_C   = 3'b011,
        COND_NC  = 3'b100,
        COND_S   = 3'b101,
        COND_O   = 3'b110,
        COND_LT  = 3'b111
    } cond_e;

    logic [3:0]    flags_q, flags_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [3:0]    stack_q [DEPTH];
    logic [3:0]    top;
    logic          stack_empty, stack_full, push_ok, pop_ok;

    assign stack_empty = (count_q == '0);
    assign stack_full  = (count_q == DEPTH_C);
    // Push and Pop together cancel each other and only raise the error.
    assign push_ok     = Push && !Pop && !stack_full;
    assign pop_ok      = Pop && !Push && !stack_empty;

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i + 1)) top = stack_q[i];
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        flags_d = flags_q;
        count_d = count_q;
        err_d   = err_q;

        if (Push && Pop) begin
            err_d = 1'b1;
        end else if (Push) begin
            if (stack_full) err_d = 1'b1;
            else            count_d = count_q + CW'(1);
        end else if (Pop) begin
            if (stack_empty) err_d = 1'b1;
            else             count_d = count_q - CW'(1);
        end

        if (pop_ok) begin
            flags_d = top;
        end else if (WrE) begin
            flags_d = WrData;
        end else if (E) begin
            flags_d = (flags_q & ~UpdMask) | (ALUFlags & UpdMask);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // see the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the stack array is deliberately not reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (count_q == CW'(i)) stack_q[i] <= flags_q;
            end
        end
    end

    always_comb begin
        CondTrue = 1'b1;
        unique case (cond_e'(Cond))
            COND_AL: CondTrue = 1'b1;
            COND_Z:  CondTrue = flags_q[3];
            COND_NZ: CondTrue = ~flags_q[3];
            COND_C:  CondTrue = flags_q[2];
            COND_NC: CondTrue = ~flags_q[2];
            COND_S:  CondTrue = flags_q[1];
            COND_O:  CondTrue = flags_q[0];
            COND_LT: CondTrue = flags_q[1] ^ flags_q[0];
            default: CondTrue = 1'b1;
        endcase
    end

    assign CFlags     = flags_q;
    assign StackEmpty = stack_empty;
    assign StackFull  = stack_full;
    assign StackErr   = err_q;

endmodule
